// File: rtl/lob_msg_dispatcher.sv
// lob_msg_dispatcher
//
// Upstream feeder for the limit order book core. Order messages are queued
// in a small FIFO, issued one at a time to the book core over its
// start/busy handshake, and each 16-bit result is returned over a
// valid/ready handshake. Illegal message types (6, 7) never reach the book
// core, and a book core that stalls in either handshake phase is abandoned
// after TIMEOUT cycles with an error result.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   in_valid/in_ready message input handshake (in_ready = FIFO not full)
//   in_type/side/id/size/limit   message fields
//   lob_start         one-cycle start pulse to the book core
//   lob_type/side/id/size/limit  held message fields to the book core
//   lob_busy, lob_out book core status and result
//   res_valid/res_ready          result handshake
//   res_type/id/data/err         completed message type, id, value, error flag
//   fifo_count        current FIFO occupancy
module lob_msg_dispatcher #(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_type,
    input  logic            in_side,
    input  logic [15:0]     in_id,
    input  logic [15:0]     in_size,
    input  logic [15:0]     in_limit,
    output logic            lob_start,
    output logic [2:0]      lob_type,
    output logic            lob_side,
    output logic [15:0]     lob_id,
    output logic [15:0]     lob_size,
    output logic [15:0]     lob_limit,
    input  logic            lob_busy,
    input  logic [15:0]     lob_out,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [2:0]      res_type,
    output logic [15:0]     res_id,
    output logic [15:0]     res_data,
    output logic            res_err,
    output logic [AW:0]     fifo_count
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_BUSY = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_RESULT    = 3'd4;
    localparam logic [2:0] S_GAP       = 3'd5;

    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
    localparam logic [15:0]   TIMER_LAST = 16'(TIMEOUT - 1);

    // FIFO storage, entry layout {type[51:49], side[48], id[47:32], size[31:16], limit[15:0]}
    logic [51:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [51:0]   head;
    logic          push;
    logic          pop;

    logic [2:0]    state;
    logic [15:0]   timer;
    logic [15:0]   timer_inc;

    logic [2:0]    hold_type;
    logic          hold_side;
    logic [15:0]   hold_id;
    logic [15:0]   hold_size;
    logic [15:0]   hold_limit;

    assign in_ready   = (count != FULL_COUNT);
    assign push       = in_valid && in_ready;
    assign pop        = (state == S_IDLE) && (count != '0);
    assign head       = mem[rd_ptr];
    assign fifo_count = count;

    // The timer saturates so a very large TIMEOUT can never wrap it back to zero.
    assign timer_inc  = (timer == 16'hFFFF) ? timer : timer + 16'd1;

    assign lob_start  = (state == S_ISSUE);
    assign res_valid  = (state == S_RESULT);

    assign lob_type   = hold_type;
    assign lob_side   = hold_side;
    assign lob_id     = hold_id;
    assign lob_size   = hold_size;
    assign lob_limit  = hold_limit;
    assign res_type   = hold_type;
    assign res_id     = hold_id;

    // Storage array needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_type, in_side, in_id, in_size, in_limit};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Dispatch FSM. The timer is cleared on every transition so each wait
    // phase gets its own full TIMEOUT budget.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            timer      <= '0;
            hold_type  <= '0;
            hold_side  <= 1'b0;
            hold_id    <= '0;
            hold_size  <= '0;
            hold_limit <= '0;
            res_data   <= '0;
            res_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        {hold_type, hold_side, hold_id, hold_size, hold_limit} <= head;
                        timer <= '0;
                        // Types 6 and 7 are answered locally and never reach the book core.
                        if (head[51:49] > 3'd5) begin
                            state    <= S_RESULT;
                            res_err  <= 1'b1;
                            res_data <= 16'h0000;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    timer <= '0;
                    state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (lob_busy) begin
                        timer <= '0;
                        state <= S_WAIT_DONE;
                    end else if (timer == TIMER_LAST) begin
                        timer    <= '0;
                        res_err  <= 1'b1;
                        res_data <= 16'hFFFF;
                        state    <= S_RESULT;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                S_WAIT_DONE: begin
                    if (!lob_busy) begin
                        timer    <= '0;
                        res_err  <= 1'b0;
                        res_data <= lob_out;
                        state    <= S_RESULT;
                    end else if (timer == TIMER_LAST) begin
                        timer    <= '0;
                        res_err  <= 1'b1;
                        res_data <= 16'hFFFF;
                        state    <= S_RESULT;
                    end else begin
                        timer <= timer_inc;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        timer <= '0;
                        state <= S_GAP;
                    end
                end
                S_GAP: begin
                    // One spare cycle lets the book core settle back to idle.
                    timer <= '0;
                    state <= S_IDLE;
                end
                default: begin
                    timer <= '0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lob_msg_dispatcher.sv
// tb_lob_msg_dispatcher
//
// Scoreboard bench for lob_msg_dispatcher. Each accepted message pushes its
// expected result (from the message type and the behaviour of the bench's
// book core model) into a queue; a monitor pops and compares whenever a
// result handshake happens. A book core model answers start pulses and
// checks that the issued fields arrive in order.
module tb_lob_msg_dispatcher;

    localparam int DEPTH   = 8;
    localparam int AW      = 3;
    localparam int TIMEOUT = 16;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_type;
    logic        in_side;
    logic [15:0] in_id;
    logic [15:0] in_size;
    logic [15:0] in_limit;
    logic        lob_start;
    logic [2:0]  lob_type;
    logic        lob_side;
    logic [15:0] lob_id;
    logic [15:0] lob_size;
    logic [15:0] lob_limit;
    logic        lob_busy;
    logic [15:0] lob_out;
    logic        res_valid;
    logic        res_ready;
    logic [2:0]  res_type;
    logic [15:0] res_id;
    logic [15:0] res_data;
    logic        res_err;
    logic [AW:0] fifo_count;

    lob_msg_dispatcher #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_type(in_type), .in_side(in_side), .in_id(in_id),
        .in_size(in_size), .in_limit(in_limit),
        .lob_start(lob_start), .lob_type(lob_type), .lob_side(lob_side),
        .lob_id(lob_id), .lob_size(lob_size), .lob_limit(lob_limit),
        .lob_busy(lob_busy), .lob_out(lob_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_type(res_type), .res_id(res_id), .res_data(res_data),
        .res_err(res_err), .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  t;
        logic [15:0] id;
        logic [15:0] data;
        logic        err;
    } exp_t;

    exp_t        expQ[$];
    logic [51:0] issueQ[$];

    int          checks = 0;
    int          errors = 0;
    int          edgeCount = 0;

    // Book model behaviour: 0 normal, 1 never raises busy, 2 holds busy until released
    int          bookMode = 0;
    bit          bookFixed = 0;
    bit          holdRelease = 0;
    logic [15:0] bookXor = 16'h0000;

    bit          holdReady = 0;
    bit          forceReady = 0;
    int          startCount = 0;
    int          lastStartEdge = -1;
    int          hsEdge = -1;
    int          validEdge = -1;
    int          acceptEdge = -1;
    bit          prevStart = 0;
    bit          prevValid = 0;

    always @(posedge clk) edgeCount++;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic failBound(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: wait bound expired at edge %0d", name, edgeCount);
    endtask

    // Called on a negedge; returns on the negedge after the accepting edge.
    task automatic applyStimulus(input logic [2:0] t, input logic s, input logic [15:0] id,
                                 input logic [15:0] sz, input logic [15:0] lim);
        int   tries;
        exp_t e;
        in_valid = 1'b1;
        in_type  = t;
        in_side  = s;
        in_id    = id;
        in_size  = sz;
        in_limit = lim;
        tries    = 0;
        while (!in_ready && tries < 300) begin
            @(negedge clk);
            tries++;
        end
        if (!in_ready) begin
            failBound("accept_wait");
        end else begin
            acceptEdge = edgeCount + 1;
            e.t  = t;
            e.id = id;
            if (t > 3'd5) begin
                e.err  = 1'b1;
                e.data = 16'h0000;
            end else if (bookMode == 1) begin
                e.err  = 1'b1;
                e.data = 16'hFFFF;
            end else begin
                e.err  = 1'b0;
                e.data = id ^ bookXor;
            end
            expQ.push_back(e);
            if (t <= 3'd5) issueQ.push_back({t, s, id, sz, lim});
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        int n;
        n = 0;
        while ((expQ.size() != 0 || res_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) failBound("drain");
        repeat (3) @(negedge clk);
    endtask

    // Result consumer and scoreboard monitor. res_ready is chosen on the
    // negedge; if it meets res_valid the handshake happens on the next edge.
    initial begin
        exp_t e;
        res_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                res_ready = 1'b0;
                prevValid = 1'b0;
                continue;
            end
            if (res_valid && !prevValid) validEdge = edgeCount;
            prevValid = res_valid;
            if (holdReady)       res_ready = 1'b0;
            else if (forceReady) res_ready = 1'b1;
            else                 res_ready = ($urandom_range(0, 3) != 0);
            if (res_valid && res_ready) begin
                hsEdge = edgeCount + 1;
                if (expQ.size() == 0) begin
                    failBound("unexpected_result");
                end else begin
                    e = expQ.pop_front();
                    checkOutput("res_type", res_type, e.t);
                    checkOutput("res_id", res_id, e.id);
                    checkOutput("res_data", res_data, e.data);
                    checkOutput("res_err", res_err, e.err);
                end
            end
        end
    end

    // Start pulses must always be single-cycle.
    always @(negedge clk) begin
        if (lob_start) checkOutput("start_single_cycle", prevStart, 0);
        prevStart = lob_start;
    end

    // Book core model: checks issued fields, then raises busy k cycles after
    // start and drops it m cycles later with its result.
    initial begin
        int          k, m, n;
        logic [51:0] expIssue;
        lob_busy = 1'b0;
        lob_out  = 16'h0000;
        forever begin
            @(negedge clk);
            if (lob_start) begin
                startCount++;
                lastStartEdge = edgeCount;
                expIssue = '0;
                if (issueQ.size() == 0) begin
                    failBound("issue_unexpected");
                end else begin
                    expIssue = issueQ.pop_front();
                    checkOutput("issue_fields", {lob_type, lob_side, lob_id, lob_size, lob_limit}, expIssue);
                end
                if (bookMode != 1) begin
                    k = bookFixed ? 2 : $urandom_range(1, 4);
                    m = bookFixed ? 5 : $urandom_range(1, 6);
                    repeat (k) @(negedge clk);
                    lob_busy = 1'b1;
                    if (bookMode == 2) begin
                        n = 0;
                        while (!holdRelease && n < 400) begin
                            @(negedge clk);
                            n++;
                        end
                        if (!holdRelease) failBound("hold_release");
                    end
                    repeat (m) @(negedge clk);
                    lob_busy = 1'b0;
                    lob_out  = expIssue[47:32] ^ bookXor;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   n;
        int   sc0;
        exp_t e;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_type  = '0;
        in_side  = 1'b0;
        in_id    = '0;
        in_size  = '0;
        in_limit = '0;
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_fifo_count", fifo_count, 0);
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_lob_start", lob_start, 0);
        checkOutput("rst_res_data", res_data, 0);
        checkOutput("rst_res_err", res_err, 0);
        checkOutput("rst_lob_id", lob_id, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] single add");
        bookFixed = 1;
        bookXor   = 16'h0000;
        sc0 = startCount;
        applyStimulus(3'd0, 1'b0, 16'd7, 16'd100, 16'd50);
        checkOutput("t1_count_after_push", fifo_count, 1);
        @(negedge clk);
        checkOutput("t1_count_after_pop", fifo_count, 0);
        waitDrain(100);
        checkOutput("t1_start_latency", lastStartEdge, acceptEdge + 1);
        checkOutput("t1_start_count", startCount - sc0, 1);
        bookFixed = 0;

        $display("[TB] illegal type");
        bookXor = 16'h5A5A;
        sc0 = startCount;
        applyStimulus(3'd6, 1'b1, 16'd3, 16'd11, 16'd22);
        waitDrain(100);
        checkOutput("illegal_no_start", startCount - sc0, 0);
        applyStimulus(3'd1, 1'b0, 16'd20, 16'd5, 16'd9);
        waitDrain(100);
        checkOutput("after_illegal_start", startCount - sc0, 1);

        $display("[TB] timeout");
        bookMode = 1;
        applyStimulus(3'd2, 1'b1, 16'd44, 16'd1, 16'd2);
        waitDrain(200);
        bookMode = 0;
        // 16 cycles in WAIT_BUSY after the ISSUE cycle
        checkOutput("timeout_latency", validEdge - lastStartEdge, TIMEOUT + 1);
        sc0 = startCount;
        applyStimulus(3'd3, 1'b0, 16'd45, 16'd3, 16'd4);
        waitDrain(200);
        checkOutput("after_timeout_start", startCount - sc0, 1);

        $display("[TB] result backpressure");
        holdReady  = 1;
        forceReady = 0;
        sc0 = startCount;
        applyStimulus(3'd4, 1'b0, 16'd60, 16'd7, 16'd8);
        applyStimulus(3'd5, 1'b1, 16'd61, 16'd9, 16'd10);
        n = 0;
        while (!res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid) failBound("hold_result_wait");
        e = expQ[0];
        for (int i = 0; i < 10; i++) begin
            checkOutput("hold_valid", res_valid, 1);
            checkOutput("hold_fields", {res_type, res_id, res_data, res_err}, {e.t, e.id, e.data, e.err});
            checkOutput("hold_no_start", lob_start, 0);
            @(negedge clk);
        end
        checkOutput("hold_start_count", startCount - sc0, 1);
        holdReady  = 0;
        forceReady = 1;
        n = 0;
        while (startCount - sc0 < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (startCount - sc0 < 2) failBound("restart_wait");
        // GAP then IDLE follow the handshake edge; the start lands two edges later
        checkOutput("restart_after_ready", lastStartEdge, hsEdge + 2);
        forceReady = 0;
        waitDrain(200);

        $display("[TB] burst with busy book");
        bookMode    = 2;
        holdRelease = 0;
        sc0 = startCount;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(3'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                          16'(100 + i), 16'($urandom), 16'($urandom));
        end
        checkOutput("burst_full_count", fifo_count, DEPTH);
        checkOutput("burst_in_ready", in_ready, 0);
        holdRelease = 1;
        waitDrain(1000);
        checkOutput("burst_starts", startCount - sc0, 9);
        bookMode    = 0;
        holdRelease = 0;

        $display("[TB] reset during WAIT_DONE");
        bookMode = 2;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(3'd0, 1'b1, 16'(200 + i), 16'd1, 16'd2);
        end
        n = 0;
        while (!lob_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!lob_busy) failBound("rst_busy_wait");
        @(negedge clk);
        checkOutput("rst_pre_count", fifo_count, 3);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_fifo_count", fifo_count, 0);
        checkOutput("rst_mid_res_valid", res_valid, 0);
        checkOutput("rst_mid_lob_start", lob_start, 0);
        checkOutput("rst_mid_in_ready", in_ready, 1);
        rst = 1'b0;
        expQ.delete();
        issueQ.delete();
        holdRelease = 1;
        n = 0;
        while (lob_busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (lob_busy) failBound("rst_release_wait");
        bookMode    = 0;
        holdRelease = 0;
        repeat (2) @(negedge clk);
        sc0 = startCount;
        applyStimulus(3'd0, 1'b0, 16'd9, 16'd9, 16'd9);
        waitDrain(200);
        checkOutput("post_rst_start", startCount - sc0, 1);

        $display("[TB] random traffic");
        bookXor = 16'($urandom);
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            applyStimulus(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          16'($urandom), 16'($urandom), 16'($urandom));
        end
        waitDrain(4000);

        checkOutput("scoreboard_empty", expQ.size(), 0);
        checkOutput("issue_queue_empty", issueQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
